// File: rtl/fix_sched_pkg.sv
// Shared definitions for the FIX session scheduler and the message builder:
// FSM state encoding and the 4-bit admin message type codes.
package fix_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOGON_ST,
        S_LOGON_WT,
        S_ACTIVE,
        S_HB_ST,
        S_HB_WT,
        S_LOGOUT_ST,
        S_LOGOUT_WT
    } sched_state_t;

    localparam logic [3:0] MSG_NONE      = 4'b0000;
    localparam logic [3:0] MSG_LOGON     = 4'b0001;
    localparam logic [3:0] MSG_HEARTBEAT = 4'b0010;
    localparam logic [3:0] MSG_LOGOUT    = 4'b0100;

    // True while a message has been started and the builder has not yet finished it.
    function automatic logic is_wait_state(input sched_state_t s);
        return (s == S_LOGON_WT) || (s == S_HB_WT) || (s == S_LOGOUT_WT);
    endfunction

endpackage

// File: rtl/fix_hb_timer.sv
// Heartbeat interval timer: holds the interval captured at logon and a
// saturating cycle counter. Expiry is flagged combinationally when the counter
// reaches interval-1; an interval of zero never expires.
module fix_hb_timer #(
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] period,
    input  logic                   clear,
    input  logic                   enable,
    output logic                   expired
);

    logic [TIMER_WIDTH-1:0] per_reg;
    logic [TIMER_WIDTH-1:0] cnt_reg;

    // Interval capture and saturating count; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            per_reg <= '0;
            cnt_reg <= '0;
        end else begin
            if (load) begin
                per_reg <= period;
            end
            if (clear) begin
                cnt_reg <= '0;
            end else if (enable && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + TIMER_WIDTH'(1);
            end
        end
    end

    assign expired = (per_reg != '0) && (cnt_reg == per_reg - TIMER_WIDTH'(1));

endmodule

// File: rtl/fix_session_scheduler.sv
// FIX session sequencer: chooses the next admin message (logon, heartbeat,
// logout), pulses msg_start_o, holds type/sequence number until the builder
// reports done, then advances MsgSeqNum (wrapping all-ones -> 1).
// Optional feature: define FIX_SCHED_WATCHDOG_EN to abort a message that the
// builder does not finish within WD_CYCLES cycles of its start pulse.
module fix_session_scheduler
    import fix_sched_pkg::*;
#(
    parameter int SEQ_WIDTH   = 32,
    parameter int TIMER_WIDTH = 32
`ifdef FIX_SCHED_WATCHDOG_EN
    ,
    parameter int WD_CYCLES   = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   logon_req_i,
    input  logic                   logout_req_i,
    input  logic [TIMER_WIDTH-1:0] hb_period_i,
    input  logic                   msg_done_i,
    output logic                   msg_start_o,
    output logic [3:0]             msg_type_o,
    output logic [SEQ_WIDTH-1:0]   seq_num_o,
    output logic                   busy_o,
    output logic                   session_active_o,
    output logic                   timeout_o
);

    sched_state_t           state_reg;
    logic                   logout_pending_reg;
    logic                   in_wait;
    logic                   done_in_wait;
    logic                   hb_load;
    logic                   hb_expired;
    logic                   timeout_fire;
    logic [SEQ_WIDTH-1:0]   seq_next;

    assign in_wait      = is_wait_state(state_reg);
    assign done_in_wait = in_wait && msg_done_i;
    assign hb_load      = (state_reg == S_IDLE) && logon_req_i;
    // Sequence number 0 is never emitted.
    assign seq_next     = (seq_num_o == '1) ? SEQ_WIDTH'(1) : seq_num_o + SEQ_WIDTH'(1);

    fix_hb_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_hb_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (hb_load),
        .period  (hb_period_i),
        .clear   (done_in_wait || hb_load),
        .enable  (state_reg == S_ACTIVE),
        .expired (hb_expired)
    );

`ifdef FIX_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            in_start;

    assign in_start     = (state_reg == S_LOGON_ST) || (state_reg == S_HB_ST) ||
                          (state_reg == S_LOGOUT_ST);
    assign timeout_fire = in_wait && !msg_done_i && (wd_cnt_reg == WD_W'(WD_CYCLES - 1));

    // Count cycles since the start pulse; idle outside a message in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_reg <= '0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= timeout_fire;
            if (in_start) begin
                wd_cnt_reg <= WD_W'(1);
            end else if (in_wait) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end else begin
                wd_cnt_reg <= '0;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Session FSM with registered outputs; a watchdog abort overrides the case.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg          <= S_IDLE;
            msg_start_o        <= 1'b0;
            msg_type_o         <= MSG_NONE;
            seq_num_o          <= SEQ_WIDTH'(1);
            busy_o             <= 1'b0;
            session_active_o   <= 1'b0;
            logout_pending_reg <= 1'b0;
        end else begin
            msg_start_o <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (logon_req_i) begin
                        state_reg   <= S_LOGON_ST;
                        msg_start_o <= 1'b1;
                        msg_type_o  <= MSG_LOGON;
                        busy_o      <= 1'b1;
                    end
                end
                S_LOGON_ST: begin
                    state_reg <= S_LOGON_WT;
                    if (logout_req_i) logout_pending_reg <= 1'b1;
                end
                S_LOGON_WT: begin
                    if (logout_req_i) logout_pending_reg <= 1'b1;
                    if (msg_done_i) begin
                        seq_num_o        <= seq_next;
                        state_reg        <= S_ACTIVE;
                        session_active_o <= 1'b1;
                        busy_o           <= 1'b0;
                        msg_type_o       <= MSG_NONE;
                    end
                end
                S_ACTIVE: begin
                    if (logout_req_i || logout_pending_reg) begin
                        state_reg          <= S_LOGOUT_ST;
                        msg_start_o        <= 1'b1;
                        msg_type_o         <= MSG_LOGOUT;
                        busy_o             <= 1'b1;
                        logout_pending_reg <= 1'b0;
                    end else if (hb_expired) begin
                        state_reg   <= S_HB_ST;
                        msg_start_o <= 1'b1;
                        msg_type_o  <= MSG_HEARTBEAT;
                        busy_o      <= 1'b1;
                    end
                end
                S_HB_ST: begin
                    state_reg <= S_HB_WT;
                    if (logout_req_i) logout_pending_reg <= 1'b1;
                end
                S_HB_WT: begin
                    if (msg_done_i) begin
                        seq_num_o <= seq_next;
                        if (logout_pending_reg || logout_req_i) begin
                            // Logout queued behind the heartbeat goes out straight away.
                            state_reg          <= S_LOGOUT_ST;
                            msg_start_o        <= 1'b1;
                            msg_type_o         <= MSG_LOGOUT;
                            logout_pending_reg <= 1'b0;
                        end else begin
                            state_reg  <= S_ACTIVE;
                            busy_o     <= 1'b0;
                            msg_type_o <= MSG_NONE;
                        end
                    end else if (logout_req_i) begin
                        logout_pending_reg <= 1'b1;
                    end
                end
                S_LOGOUT_ST: begin
                    state_reg <= S_LOGOUT_WT;
                end
                S_LOGOUT_WT: begin
                    if (msg_done_i) begin
                        seq_num_o          <= seq_next;
                        state_reg          <= S_IDLE;
                        session_active_o   <= 1'b0;
                        busy_o             <= 1'b0;
                        msg_type_o         <= MSG_NONE;
                        logout_pending_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
            if (timeout_fire) begin
                state_reg          <= S_IDLE;
                busy_o             <= 1'b0;
                msg_type_o         <= MSG_NONE;
                session_active_o   <= 1'b0;
                logout_pending_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fix_session_scheduler.sv
// Bench for fix_session_scheduler: a vector table for the logon handshake,
// hand-written sequences for heartbeat timing, logout collisions, sequence
// wrap, mid-message reset and the optional watchdog, and a scoreboard that
// checks every start pulse against the message the bench expects next.
`timescale 1ns/1ps
module tb_fix_session_scheduler;
    import fix_sched_pkg::*;

    localparam int SW = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          logon_req_i = 1'b0;
    logic          logout_req_i = 1'b0;
    logic          msg_done_i = 1'b0;
    logic [TW-1:0] hb_period_i = '0;
    logic          msg_start_o;
    logic [3:0]    msg_type_o;
    logic [SW-1:0] seq_num_o;
    logic          busy_o;
    logic          session_active_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]    mtype;
        logic [SW-1:0] seq;
    } exp_msg_t;

    exp_msg_t sb_q[$];

    typedef struct {
        logic          logon;
        logic          logout;
        logic          done;
        logic [TW-1:0] hb;
        logic          start;
        logic [3:0]    mtype;
        logic [SW-1:0] seq;
        logic          busy;
        logic          active;
    } vec_t;

    always #5 clk = ~clk;

    fix_session_scheduler #(
        .SEQ_WIDTH   (SW),
        .TIMER_WIDTH (TW)
`ifdef FIX_SCHED_WATCHDOG_EN
        ,
        .WD_CYCLES   (8)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .logon_req_i      (logon_req_i),
        .logout_req_i     (logout_req_i),
        .hb_period_i      (hb_period_i),
        .msg_done_i       (msg_done_i),
        .msg_start_o      (msg_start_o),
        .msg_type_o       (msg_type_o),
        .seq_num_o        (seq_num_o),
        .busy_o           (busy_o),
        .session_active_o (session_active_o),
        .timeout_o        (timeout_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [SW-1:0] s);
        exp_msg_t e;
        e.mtype = t;
        e.seq   = s;
        sb_q.push_back(e);
    endtask

    task automatic pulse_done();
        msg_done_i = 1'b1;
        tick();
        msg_done_i = 1'b0;
    endtask

    // Advance until a start pulse is visible, giving up after max_cycles.
    task automatic wait_start(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((msg_start_o !== 1'b1) && (n < max_cycles));
    endtask

    function automatic logic [SW-1:0] seq_inc(input logic [SW-1:0] v);
        logic [SW-1:0] top;
        top = '1;
        return (v == top) ? SW'(1) : v + SW'(1);
    endfunction

    function automatic vec_t mk(input logic logon, input logic logout, input logic done,
                                input logic [TW-1:0] hb, input logic start, input logic [3:0] t,
                                input logic [SW-1:0] s, input logic busy, input logic active);
        vec_t v;
        v.logon = logon; v.logout = logout; v.done = done; v.hb = hb;
        v.start = start; v.mtype = t; v.seq = s; v.busy = busy; v.active = active;
        return v;
    endfunction

    // Scoreboard: every start pulse must match the oldest expected message.
    always @(negedge clk) begin
        if (msg_start_o === 1'b1) begin
            $display("start: type=%0h seq=%0d", msg_type_o, seq_num_o);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_start: got type %0h seq %0d, expected no message",
                         msg_type_o, seq_num_o);
            end else begin
                exp_msg_t e;
                e = sb_q.pop_front();
                chk("sb_type", msg_type_o, e.mtype);
                chk("sb_seq", seq_num_o, e.seq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        vec_t          vt[8];
        int            n;
        int            seen;
        logic [SW-1:0] es;

        // Logon handshake, one row per cycle; outputs checked after the edge.
        vt[0] = mk(0, 1, 1, 16'd0,  0, MSG_NONE,  4'd1, 0, 0);  // done/logout in IDLE ignored
        vt[1] = mk(1, 0, 0, 16'd10, 1, MSG_LOGON, 4'd1, 1, 0);  // logon -> LOGON_ST
        vt[2] = mk(1, 0, 0, 16'd3,  0, MSG_LOGON, 4'd1, 1, 0);  // logon/hb ignored outside IDLE
        vt[3] = mk(0, 0, 0, 16'd0,  0, MSG_LOGON, 4'd1, 1, 0);
        vt[4] = mk(0, 0, 0, 16'd0,  0, MSG_LOGON, 4'd1, 1, 0);
        vt[5] = mk(0, 0, 0, 16'd0,  0, MSG_LOGON, 4'd1, 1, 0);
        vt[6] = mk(0, 0, 0, 16'd0,  0, MSG_LOGON, 4'd1, 1, 0);
        vt[7] = mk(0, 0, 1, 16'd0,  0, MSG_NONE,  4'd2, 0, 1);  // done 5 cycles after start

        rst = 1'b0;
        repeat (3) tick();
        chk("reset_start",   msg_start_o,      0);
        chk("reset_type",    msg_type_o,       MSG_NONE);
        chk("reset_seq",     seq_num_o,        1);
        chk("reset_busy",    busy_o,           0);
        chk("reset_active",  session_active_o, 0);
        chk("reset_timeout", timeout_o,        0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logon_req_i  = vt[i].logon;
            logout_req_i = vt[i].logout;
            msg_done_i   = vt[i].done;
            hb_period_i  = vt[i].hb;
            if (vt[i].start) push_exp(vt[i].mtype, vt[i].seq);
            tick();
            chk($sformatf("vec%0d_start", i),  msg_start_o,      vt[i].start);
            chk($sformatf("vec%0d_type", i),   msg_type_o,       vt[i].mtype);
            chk($sformatf("vec%0d_seq", i),    seq_num_o,        vt[i].seq);
            chk($sformatf("vec%0d_busy", i),   busy_o,           vt[i].busy);
            chk($sformatf("vec%0d_active", i), session_active_o, vt[i].active);
        end
        logon_req_i = 1'b0; logout_req_i = 1'b0; msg_done_i = 1'b0; hb_period_i = '0;

        // First heartbeat: 10 cycles after the first ACTIVE cycle.
        push_exp(MSG_HEARTBEAT, 4'd2);
        wait_start(30, n);
        chk("hb1_latency", n, 10);
        chk("hb1_type", msg_type_o, MSG_HEARTBEAT);
        tick();
        chk("hb1_wait_start", msg_start_o, 0);
        chk("hb1_wait_busy", busy_o, 1);
        pulse_done();
        chk("hb1_seq_after", seq_num_o, 3);
        chk("hb1_busy_after", busy_o, 0);
        chk("hb1_type_after", msg_type_o, MSG_NONE);

        // Logout requested while the heartbeat is in flight.
        push_exp(MSG_HEARTBEAT, 4'd3);
        wait_start(30, n);
        chk("hb2_latency", n, 10);
        tick();
        logout_req_i = 1'b1;
        tick();
        logout_req_i = 1'b0;
        chk("pend_hb_held", msg_type_o, MSG_HEARTBEAT);
        tick();
        push_exp(MSG_LOGOUT, 4'd4);
        pulse_done();
        chk("pend_logout_start", msg_start_o, 1);
        chk("pend_logout_type", msg_type_o, MSG_LOGOUT);
        chk("pend_logout_seq", seq_num_o, 4);
        chk("pend_active", session_active_o, 1);
        tick();
        pulse_done();
        chk("pend_idle_active", session_active_o, 0);
        chk("pend_idle_seq", seq_num_o, 5);
        chk("pend_idle_busy", busy_o, 0);

        // Logout arriving in the same cycle as heartbeat expiry wins.
        hb_period_i = 16'd4;
        logon_req_i = 1'b1;
        push_exp(MSG_LOGON, 4'd5);
        tick();
        logon_req_i = 1'b0;
        tick();
        pulse_done();
        chk("coll_active", session_active_o, 1);
        repeat (3) tick();
        chk("coll_no_hb_yet", msg_start_o, 0);
        logout_req_i = 1'b1;
        push_exp(MSG_LOGOUT, 4'd6);
        tick();
        logout_req_i = 1'b0;
        chk("coll_start", msg_start_o, 1);
        chk("coll_type", msg_type_o, MSG_LOGOUT);
        tick();
        pulse_done();
        chk("coll_idle_active", session_active_o, 0);
        chk("coll_idle_seq", seq_num_o, 7);

        // Back-to-back heartbeats across the sequence wrap.
        hb_period_i = 16'd1;
        logon_req_i = 1'b1;
        es = 4'd7;
        push_exp(MSG_LOGON, es);
        tick();
        logon_req_i = 1'b0;
        tick();
        pulse_done();
        es = seq_inc(es);
        chk("wrap_logon_seq", seq_num_o, es);
        for (int k = 0; k < 10; k++) begin
            push_exp(MSG_HEARTBEAT, es);
            wait_start(5, n);
            chk($sformatf("wrap%0d_start", k), msg_start_o, 1);
            tick();
            pulse_done();
            es = seq_inc(es);
            chk($sformatf("wrap%0d_seq", k), seq_num_o, es);
        end

        // Reset in the middle of a heartbeat.
        push_exp(MSG_HEARTBEAT, es);
        wait_start(5, n);
        tick();
        chk("rst_mid_busy_before", busy_o, 1);
        rst = 1'b0;
        tick();
        chk("rst_mid_start",   msg_start_o,      0);
        chk("rst_mid_type",    msg_type_o,       MSG_NONE);
        chk("rst_mid_seq",     seq_num_o,        1);
        chk("rst_mid_busy",    busy_o,           0);
        chk("rst_mid_active",  session_active_o, 0);
        chk("rst_mid_timeout", timeout_o,        0);
        rst = 1'b1;
        tick();
        pulse_done();
        chk("rst_idle_done_seq", seq_num_o, 1);

        // Heartbeats disabled: nothing is sent until logout.
        hb_period_i = 16'd0;
        logon_req_i = 1'b1;
        push_exp(MSG_LOGON, 4'd1);
        tick();
        logon_req_i = 1'b0;
        tick();
        pulse_done();
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (msg_start_o === 1'b1) seen++;
        end
        chk("hboff_no_start", seen, 0);
        logout_req_i = 1'b1;
        push_exp(MSG_LOGOUT, 4'd2);
        tick();
        logout_req_i = 1'b0;
        chk("hboff_logout_start", msg_start_o, 1);
        tick();
        pulse_done();
        chk("hboff_idle_seq", seq_num_o, 3);

        // Builder never answers a logon.
        logon_req_i = 1'b1;
        push_exp(MSG_LOGON, 4'd3);
        tick();
        logon_req_i = 1'b0;
`ifdef FIX_SCHED_WATCHDOG_EN
        n = 0;
        do begin
            tick();
            n++;
        end while ((timeout_o !== 1'b1) && (n < 20));
        chk("wd_latency", n, 8);
        chk("wd_busy", busy_o, 0);
        chk("wd_active", session_active_o, 0);
        chk("wd_seq", seq_num_o, 3);
        chk("wd_type", msg_type_o, MSG_NONE);
        tick();
        chk("wd_pulse_end", timeout_o, 0);
`else
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (timeout_o !== 1'b0) seen++;
        end
        chk("nowd_timeout", seen, 0);
        chk("nowd_busy", busy_o, 1);
        pulse_done();
        chk("nowd_seq", seq_num_o, 4);
        chk("nowd_active", session_active_o, 1);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
